// File: rtl/uvmt_axil_st_slv_mem_pkg.sv
// Shared definitions for the AXI4-Lite self-test responder memory.
// Holds the response codes, the write/read FSM state encodings and the
// constants of the optional backpressure LFSR.
package uvmt_axil_st_slv_mem_pkg;

  // AXI response codes
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE    = 2'd0,
    W_COLLECT = 2'd1,
    W_RESP    = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  // Backpressure LFSR: taps 16,14,13,11 expressed as a mask over the
  // right-shifting register (taps land on bits 0,2,3,5), seeded with ACE1.
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {^(cur & LFSR_TAPS), cur[15:1]};
  endfunction

endpackage

// File: rtl/uvmt_axil_st_slv_mem_ram.sv
// Word memory with a byte-enabled write port and one registered read port.
// Latency: read data valid the cycle after rd_en; write committed on the edge.
// Backpressure: none, accepts one write and one read every cycle.
// Ports: clk; wr_en/wr_idx/wr_dat/wr_be write port; rd_en/rd_idx/rd_dat read port.
// A read and write to the same index on the same edge returns the old word.
module uvmt_axil_st_slv_mem_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_idx,
  input  logic [DATA_WIDTH-1:0]      wr_dat,
  input  logic [DATA_WIDTH/8-1:0]    wr_be,
  input  logic                       rd_en,
  input  logic [$clog2(DEPTH)-1:0]   rd_idx,
  output logic [DATA_WIDTH-1:0]      rd_dat
);

  localparam int BE_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < BE_W; b++) begin
        if (wr_be[b]) mem[wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
      end
    end
    if (rd_en) rd_dat <= mem[rd_idx];
  end

endmodule

// File: rtl/uvmt_axil_st_slv_mem.sv
// AXI4-Lite responder backed by a byte-enabled word memory; DECERR out of range.
// Latency: AW+W handshake to bvalid 1 cycle; AR handshake to rvalid 1 cycle.
// Backpressure: readies drop after their handshake until B/R is taken; B/R held until ready.
// Ports: clk, reset (sync, active-high); AW/W/B write channels; AR/R read channels.
// DATA_WIDTH must be 32 or 64, DEPTH a power of two.
// Macro UVMT_AXIL_ST_SLV_MEM_BP_EN adds LFSR-driven random ready/valid stalls.
module uvmt_axil_st_slv_mem
  import uvmt_axil_st_slv_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = $clog2(DEPTH);

  // ---------------------------------------------------------------------
  // Stall sources
  // ---------------------------------------------------------------------
  logic aw_stall, w_stall, ar_stall, v_hold;

`ifdef UVMT_AXIL_ST_SLV_MEM_BP_EN
  logic [15:0] lfsr;

  always_ff @(posedge clk) begin
    if (reset) lfsr <= LFSR_SEED;
    else       lfsr <= lfsr_next(lfsr);
  end

  assign aw_stall = lfsr[0];
  assign w_stall  = lfsr[1];
  assign ar_stall = lfsr[2];
  assign v_hold   = lfsr[3];
`else
  assign aw_stall = 1'b0;
  assign w_stall  = 1'b0;
  assign ar_stall = 1'b0;
  assign v_hold   = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------
  w_state_t               w_state;
  logic                   awready_q, wready_q;
  logic                   aw_got, w_got;
  logic [ADDR_WIDTH-1:0]  awaddr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [STRB_W-1:0]      wstrb_q;

  logic                   aw_hs, w_hs, wr_commit, wr_in_range;
  logic [ADDR_WIDTH-1:0]  wr_addr;
  logic [DATA_WIDTH-1:0]  wr_data;
  logic [STRB_W-1:0]      wr_strb;

  assign awready = awready_q & ~aw_stall;
  assign wready  = wready_q & ~w_stall;
  assign aw_hs   = awvalid & awready;
  assign w_hs    = wvalid & wready;

  // A channel captured earlier comes from its holding register; one arriving
  // this cycle is used straight off the bus so the commit needs no extra cycle.
  assign wr_addr = aw_got ? awaddr_q : awaddr;
  assign wr_data = w_got  ? wdata_q  : wdata;
  assign wr_strb = w_got  ? wstrb_q  : wstrb;

  assign wr_commit   = (w_state != W_RESP) && (aw_got || aw_hs) && (w_got || w_hs);
  assign wr_in_range = (wr_addr >> (OFF_W + IDX_W)) == '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state   <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      aw_got    <= 1'b0;
      w_got     <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= OKAY;
    end else begin
      case (w_state)
        W_IDLE, W_COLLECT: begin
          if (aw_hs) begin
            awready_q <= 1'b0;
            awaddr_q  <= awaddr;
          end
          if (w_hs) begin
            wready_q <= 1'b0;
            wdata_q  <= wdata;
            wstrb_q  <= wstrb;
          end
          if (wr_commit) begin
            aw_got  <= 1'b0;
            w_got   <= 1'b0;
            w_state <= W_RESP;
            bvalid  <= ~v_hold;
            bresp   <= wr_in_range ? OKAY : DECERR;
          end else begin
            aw_got  <= aw_got | aw_hs;
            w_got   <= w_got | w_hs;
            w_state <= (aw_got || aw_hs || w_got || w_hs) ? W_COLLECT : W_IDLE;
          end
        end
        W_RESP: begin
          if (!bvalid) begin
            if (!v_hold) bvalid <= 1'b1;
          end else if (bready) begin
            bvalid    <= 1'b0;
            awready_q <= 1'b1;
            wready_q  <= 1'b1;
            w_state   <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------
  r_state_t               r_state;
  logic                   arready_q;
  logic                   ar_hs, rd_in_range;
  logic                   rd_ok;
  logic [DATA_WIDTH-1:0]  ram_rdat;

  assign arready     = arready_q & ~ar_stall;
  assign ar_hs       = arvalid & arready;
  assign rd_in_range = (araddr >> (OFF_W + IDX_W)) == '0;

  // The RAM read register only updates on an AR handshake, so rdata stays
  // stable through R_DATA; rd_ok zeroes it after reset and for DECERR reads.
  assign rdata = rd_ok ? ram_rdat : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= R_IDLE;
      arready_q <= 1'b1;
      rvalid    <= 1'b0;
      rresp     <= OKAY;
      rd_ok     <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            arready_q <= 1'b0;
            rd_ok     <= rd_in_range;
            rresp     <= rd_in_range ? OKAY : DECERR;
            rvalid    <= ~v_hold;
            r_state   <= R_DATA;
          end
        end
        R_DATA: begin
          if (!rvalid) begin
            if (!v_hold) rvalid <= 1'b1;
          end else if (rready) begin
            rvalid    <= 1'b0;
            arready_q <= 1'b1;
            r_state   <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  uvmt_axil_st_slv_mem_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_commit && wr_in_range),
    .wr_idx (wr_addr[OFF_W +: IDX_W]),
    .wr_dat (wr_data),
    .wr_be  (wr_strb),
    .rd_en  (ar_hs),
    .rd_idx (araddr[OFF_W +: IDX_W]),
    .rd_dat (ram_rdat)
  );

endmodule

// File: tb/tb_uvmt_axil_st_slv_mem.sv
// Directed bench for uvmt_axil_st_slv_mem in its default build (no stalls).
// Inputs change 1 time unit after the rising edge and outputs are checked
// there too, so every check sees the state settled by the preceding edge.
module tb_uvmt_axil_st_slv_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uvmt_axil_st_slv_mem #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .DEPTH      (256)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .awaddr  (awaddr),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wvalid  (wvalid),
    .wready  (wready),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready),
    .araddr  (araddr),
    .arvalid (arvalid),
    .arready (arready),
    .rdata   (rdata),
    .rresp   (rresp),
    .rvalid  (rvalid),
    .rready  (rready)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // AW and W presented together; response taken immediately.
  task automatic do_write(input string tag, input logic [31:0] addr,
                          input logic [31:0] data, input logic [3:0] strb,
                          input logic [1:0] exp_resp);
    awaddr = addr; awvalid = 1'b1;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    step();
    chk({tag, ".bvalid"}, 32'(bvalid), 32'd1);
    chk({tag, ".bresp"}, 32'(bresp), 32'(exp_resp));
    chk({tag, ".awready_lo"}, 32'(awready), 32'd0);
    chk({tag, ".wready_lo"}, 32'(wready), 32'd0);
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    step();
    chk({tag, ".bvalid_clr"}, 32'(bvalid), 32'd0);
    chk({tag, ".awready_hi"}, 32'(awready), 32'd1);
    chk({tag, ".wready_hi"}, 32'(wready), 32'd1);
    bready = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_data, input logic [1:0] exp_resp);
    araddr = addr; arvalid = 1'b1;
    step();
    chk({tag, ".rvalid"}, 32'(rvalid), 32'd1);
    chk({tag, ".arready_lo"}, 32'(arready), 32'd0);
    chk({tag, ".rdata"}, rdata, exp_data);
    chk({tag, ".rresp"}, 32'(rresp), 32'(exp_resp));
    arvalid = 1'b0; rready = 1'b1;
    step();
    chk({tag, ".rvalid_clr"}, 32'(rvalid), 32'd0);
    chk({tag, ".arready_hi"}, 32'(arready), 32'd1);
    rready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0;
    bready = 1'b0; araddr = '0; arvalid = 1'b0; rready = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();

    // Reset state
    chk("rst.awready", 32'(awready), 32'd1);
    chk("rst.wready", 32'(wready), 32'd1);
    chk("rst.arready", 32'(arready), 32'd1);
    chk("rst.bvalid", 32'(bvalid), 32'd0);
    chk("rst.rvalid", 32'(rvalid), 32'd0);
    chk("rst.bresp", 32'(bresp), 32'd0);
    chk("rst.rresp", 32'(rresp), 32'd0);
    chk("rst.rdata", rdata, 32'd0);

    // Known contents for index 0, 0x20 and 0x30
    do_write("init0", 32'h0, 32'h1234_5678, 4'hF, 2'b00);
    do_write("init20", 32'h20, 32'h0, 4'hF, 2'b00);
    do_write("init30", 32'h30, 32'h0, 4'hF, 2'b00);

    // Simultaneous AW+W, then read back
    do_write("wr10", 32'h10, 32'hDEAD_BEEF, 4'hF, 2'b00);
    do_read("rd10", 32'h10, 32'hDEAD_BEEF, 2'b00);

    // W three cycles ahead of AW, partial strobes
    wdata = 32'h1122_3344; wstrb = 4'h5; wvalid = 1'b1;
    step();
    chk("wfirst.wready_lo", 32'(wready), 32'd0);
    chk("wfirst.awready_hi", 32'(awready), 32'd1);
    chk("wfirst.bvalid0", 32'(bvalid), 32'd0);
    wvalid = 1'b0; wdata = 32'hFFFF_FFFF; wstrb = 4'hF;
    step();
    step();
    chk("wfirst.bvalid_wait", 32'(bvalid), 32'd0);
    awaddr = 32'h20; awvalid = 1'b1;
    step();
    chk("wfirst.bvalid", 32'(bvalid), 32'd1);
    chk("wfirst.bresp", 32'(bresp), 32'd0);
    awvalid = 1'b0; bready = 1'b1;
    step();
    chk("wfirst.bvalid_clr", 32'(bvalid), 32'd0);
    bready = 1'b0;
    do_read("rd20", 32'h20, 32'h0022_0044, 2'b00);

    // Out of range: index 256 aliases index 0 in the low bits but must not write
    do_write("wr400", 32'h400, 32'hFFFF_FFFF, 4'hF, 2'b11);
    do_read("rd400", 32'h400, 32'h0, 2'b11);
    do_read("rd0", 32'h0, 32'h1234_5678, 2'b00);

    // B held under bready=0 for 5 cycles, a new AW waiting meanwhile
    awaddr = 32'h40; awvalid = 1'b1;
    wdata = 32'hCAFE_F00D; wstrb = 4'hF; wvalid = 1'b1;
    step();
    wvalid = 1'b0; awaddr = 32'h44;
    for (int i = 0; i < 5; i++) begin
      chk("bhold.bvalid", 32'(bvalid), 32'd1);
      chk("bhold.bresp", 32'(bresp), 32'd0);
      chk("bhold.awready", 32'(awready), 32'd0);
      chk("bhold.wready", 32'(wready), 32'd0);
      step();
    end
    bready = 1'b1;
    step();
    chk("bhold.bvalid_clr", 32'(bvalid), 32'd0);
    chk("bhold.awready_back", 32'(awready), 32'd1);
    bready = 1'b0;
    step();
    chk("bhold.aw2_taken", 32'(awready), 32'd0);
    chk("bhold.aw2_wready", 32'(wready), 32'd1);
    chk("bhold.aw2_nob", 32'(bvalid), 32'd0);
    awvalid = 1'b0; wdata = 32'h0BAD_CAFE; wvalid = 1'b1;
    step();
    chk("bhold.b2_bvalid", 32'(bvalid), 32'd1);
    wvalid = 1'b0; bready = 1'b1;
    step();
    bready = 1'b0;
    do_read("rd40", 32'h40, 32'hCAFE_F00D, 2'b00);
    do_read("rd44", 32'h44, 32'h0BAD_CAFE, 2'b00);

    // Write commit and AR sampled on the same edge, same index
    awaddr = 32'h30; awvalid = 1'b1; wdata = 32'hA5A5_A5A5; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 32'h30; arvalid = 1'b1;
    step();
    chk("same.bvalid", 32'(bvalid), 32'd1);
    chk("same.rvalid", 32'(rvalid), 32'd1);
    chk("same.rdata_old", rdata, 32'h0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    bready = 1'b1; rready = 1'b1;
    step();
    bready = 1'b0; rready = 1'b0;
    do_read("same.rd30", 32'h30, 32'hA5A5_A5A5, 2'b00);

    // Reset while R is pending
    araddr = 32'h10; arvalid = 1'b1;
    step();
    chk("rstmid.rvalid", 32'(rvalid), 32'd1);
    arvalid = 1'b0; reset = 1'b1;
    step();
    chk("rstmid.rvalid_drop", 32'(rvalid), 32'd0);
    chk("rstmid.arready", 32'(arready), 32'd1);
    chk("rstmid.rdata", rdata, 32'h0);
    reset = 1'b0;
    step();
    do_read("rstmid.rd10", 32'h10, 32'hDEAD_BEEF, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
